execute_cc_stage: RTL and testbench

Execute stage of the Y86-64 processor. Sits directly downstream of the decode/register-file block. Takes the decoded fields (icode, ifun, rB, valC) and the register read values (valA, valB), then computes valE and Cnd and selects dstE. It owns the architectural condition-code register (ZF, SF, OF). Results are registered so the memory/write-back stage sees them one cycle after the stage advances.

---
 rtl/execute_cc_stage_if.sv | 30 +++
 rtl/execute_cc_stage.sv | 133 +++++++++++++
 tb/tb_execute_cc_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_cc_stage_if.sv
// Decode-to-execute bus: decoded fields and operands in, registered execute results out.
// The stage drives the result half; the upstream/bench side drives the instruction half.
interface execute_cc_stage_if;
  logic        en;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;

  logic [3:0]  e_icode;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  cc;
  logic        e_error;
  logic        e_halted;

  modport master (
    output en, icode, ifun, rB, valA, valB, valC,
    input  e_icode, e_valE, e_valA, e_Cnd, e_dstE, cc, e_error, e_halted
  );

  modport slave (
    input  en, icode, ifun, rB, valA, valB, valC,
    output e_icode, e_valE, e_valA, e_Cnd, e_dstE, cc, e_error, e_halted
  );
endinterface

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: ALU, condition evaluation, dstE selection and the CC register.
// All results are registered; error or halt freezes the stage until reset.
module execute_cc_stage (
    input  logic                 clk,
    input  logic                 rst_n,
    execute_cc_stage_if.slave    ex
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
        I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    logic        zf, sf, of;
    logic        cond_true;
    logic        cond_bad;
    logic [63:0] alu;
    logic        alu_of;
    logic        bad;
    logic [63:0] val_e;
    logic [3:0]  dst_e;
    logic        cnd;
    logic        cc_we;

    assign {zf, sf, of} = ex.cc;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        cond_true = 1'b0;
        cond_bad  = 1'b0;
        case (ex.ifun)
            4'h0:    cond_true = 1'b1;
            4'h1:    cond_true = (sf ^ of) | zf;
            4'h2:    cond_true = sf ^ of;
            4'h3:    cond_true = zf;
            4'h4:    cond_true = ~zf;
            4'h5:    cond_true = ~(sf ^ of);
            4'h6:    cond_true = ~(sf ^ of) & ~zf;
            default: cond_bad  = 1'b1;
        endcase
    end

    always_comb begin
        alu    = '0;
        alu_of = 1'b0;
        case (ex.ifun)
            4'h0: begin
                alu    = ex.valB + ex.valA;
                alu_of = (ex.valA[63] == ex.valB[63]) && (alu[63] != ex.valB[63]);
            end
            4'h1: begin
                alu    = ex.valB - ex.valA;
                alu_of = (ex.valA[63] != ex.valB[63]) && (alu[63] != ex.valB[63]);
            end
            4'h2:    alu = ex.valB & ex.valA;
            4'h3:    alu = ex.valB ^ ex.valA;
            default: alu = '0;
        endcase
    end

    always_comb begin
        val_e = '0;
        dst_e = R_NONE;
        cnd   = 1'b0;
        cc_we = 1'b0;
        bad   = (ex.ifun != 4'h0);
        case (icode_e'(ex.icode))
            I_HALT, I_NOP, I_RMMOVQ, I_MRMOVQ, I_IRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: begin
                case (icode_e'(ex.icode))
                    I_IRMOVQ: begin val_e = ex.valC; dst_e = ex.rB; end
                    I_RMMOVQ, I_MRMOVQ: val_e = ex.valB + ex.valC;
                    I_CALL, I_PUSHQ: begin val_e = ex.valB - 64'd8; dst_e = R_RSP; end
                    I_RET, I_POPQ:   begin val_e = ex.valB + 64'd8; dst_e = R_RSP; end
                    default: val_e = '0;
                endcase
            end
            I_RRMOVQ: begin
                bad   = cond_bad;
                val_e = ex.valA;
                cnd   = cond_true;
                dst_e = cond_true ? ex.rB : R_NONE;
            end
            I_JXX: begin
                bad = cond_bad;
                cnd = cond_true;
            end
            I_OPQ: begin
                bad   = (ex.ifun > 4'h3);
                val_e = alu;
                dst_e = ex.rB;
                cc_we = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex.e_icode  <= 4'h1;
            ex.e_valE   <= '0;
            ex.e_valA   <= '0;
            ex.e_Cnd    <= 1'b0;
            ex.e_dstE   <= R_NONE;
            ex.cc       <= 3'b100;
            ex.e_error  <= 1'b0;
            ex.e_halted <= 1'b0;
        end else if (ex.en && !ex.e_halted) begin
            ex.e_icode <= ex.icode;
            ex.e_valA  <= ex.valA;
            if (bad) begin
                ex.e_valE   <= '0;
                ex.e_dstE   <= R_NONE;
                ex.e_Cnd    <= 1'b0;
                ex.e_error  <= 1'b1;
                ex.e_halted <= 1'b1;
            end else begin
                ex.e_valE <= val_e;
                ex.e_dstE <= dst_e;
                ex.e_Cnd  <= cnd;
                if (cc_we)
                    ex.cc <= {(alu == 64'd0), alu[63], alu_of};
                if (ex.icode == I_HALT)
                    ex.e_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute_cc_stage.sv
// Self-checking bench for execute_cc_stage: directed scenarios plus a randomized run
// compared against an instruction-level reference model.
module tb_execute_cc_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_cc_stage_if ex();

  execute_cc_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (architectural view of the stage)
  bit [3:0]  m_icode, m_dstE;
  bit [63:0] m_valE, m_valA;
  bit        m_cnd, m_zf, m_sf, m_of, m_err, m_halt;

  task automatic model_edge(input bit r, input bit e, input bit [3:0] ic, input bit [3:0] fn,
                            input bit [3:0] rb, input bit [63:0] a, input bit [63:0] b,
                            input bit [63:0] c);
    bit [6:0]  conds;
    bit        lt, cond, bad;
    bit [64:0] wide;
    if (!r) begin
      m_icode = 4'h1; m_valE = '0; m_valA = '0; m_cnd = 0; m_dstE = 4'hF;
      m_zf = 1; m_sf = 0; m_of = 0; m_err = 0; m_halt = 0;
      return;
    end
    if (!e || m_halt) return;
    lt    = m_sf ^ m_of;
    conds = {!lt && !m_zf, !lt, !m_zf, m_zf, lt, lt || m_zf, 1'b1};
    cond  = (fn < 7) ? conds[fn[2:0]] : 1'b0;
    bad   = (ic > 11) || (ic == 6 && fn > 3) || ((ic == 2 || ic == 7) && fn > 6) ||
            (!(ic inside {4'd2, 4'd6, 4'd7}) && fn != 0);
    m_icode = ic;
    m_valA  = a;
    m_valE  = '0;
    m_dstE  = 4'hF;
    m_cnd   = 0;
    if (bad) begin
      m_err = 1; m_halt = 1;
      return;
    end
    case (ic)
      4'd0: m_halt = 1;
      4'd2: begin m_valE = a; m_cnd = cond; if (cond) m_dstE = rb; end
      4'd3: begin m_valE = c; m_dstE = rb; end
      4'd4, 4'd5: m_valE = b + c;
      4'd6: begin
        m_dstE = rb;
        m_of   = 0;
        case (fn)
          4'd0: begin wide = {b[63], b} + {a[63], a}; m_valE = wide[63:0]; m_of = wide[64] != wide[63]; end
          4'd1: begin wide = {b[63], b} - {a[63], a}; m_valE = wide[63:0]; m_of = wide[64] != wide[63]; end
          4'd2: m_valE = a & b;
          default: m_valE = a ^ b;
        endcase
        m_zf = (m_valE == 0);
        m_sf = m_valE[63];
      end
      4'd7: m_cnd = cond;
      4'd8, 4'd10: begin m_valE = b - 8; m_dstE = 4'd4; end
      4'd9, 4'd11: begin m_valE = b + 8; m_dstE = 4'd4; end
      default: ;
    endcase
  endtask

  task automatic issue(input bit r, input bit e, input bit [3:0] ic, input bit [3:0] fn,
                       input bit [3:0] rb, input bit [63:0] a, input bit [63:0] b,
                       input bit [63:0] c);
    rst_n = r; ex.en = e; ex.icode = ic; ex.ifun = fn; ex.rB = rb;
    ex.valA = a; ex.valB = b; ex.valC = c;
    @(posedge clk);
    model_edge(r, e, ic, fn, rb, a, b, c);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++)
      issue(0, 1, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
    n_checks++;
    if ({ex.e_icode, ex.e_valE, ex.e_dstE, ex.cc, ex.e_error, ex.e_halted} !==
        {4'h1, 64'h0, 4'hF, 3'b100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: got icode=%h valE=%h dstE=%h cc=%b err=%b halt=%b want 1/0/F/100/0/0",
               ex.e_icode, ex.e_valE, ex.e_dstE, ex.cc, ex.e_error, ex.e_halted);
    end
  endtask

  task automatic test_opq;
    issue(1, 1, 6, 0, 3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    n_checks++;
    if ({ex.e_valE, ex.e_dstE, ex.cc} !== {64'hFFFF_FFFF_FFFF_FFFE, 4'h3, 3'b011}) begin
      n_fail++;
      $display("FAIL add_ovf: got valE=%h dstE=%h cc=%b want FFFFFFFFFFFFFFFE/3/011",
               ex.e_valE, ex.e_dstE, ex.cc);
    end
    issue(1, 1, 6, 1, 3, 5, 5, 0);
    n_checks++;
    if ({ex.e_valE, ex.cc} !== {64'h0, 3'b100}) begin
      n_fail++;
      $display("FAIL sub_zero: got valE=%h cc=%b want 0/100", ex.e_valE, ex.cc);
    end
  endtask

  task automatic test_cond;
    issue(1, 1, 6, 1, 7, 5, 2, 0);
    n_checks++;
    if (ex.cc !== 3'b010) begin
      n_fail++;
      $display("FAIL sub_neg_cc: got cc=%b want 010", ex.cc);
    end
    issue(1, 1, 2, 2, 6, 42, 0, 0);
    n_checks++;
    if ({ex.e_valE, ex.e_Cnd, ex.e_dstE} !== {64'd42, 1'b1, 4'h6}) begin
      n_fail++;
      $display("FAIL cmovl: got valE=%h Cnd=%b dstE=%h want 2a/1/6", ex.e_valE, ex.e_Cnd, ex.e_dstE);
    end
    issue(1, 1, 7, 6, 4'hF, 0, 0, 64'h400);
    n_checks++;
    if ({ex.e_Cnd, ex.cc, ex.e_dstE} !== {1'b0, 3'b010, 4'hF}) begin
      n_fail++;
      $display("FAIL jg: got Cnd=%b cc=%b dstE=%h want 0/010/F", ex.e_Cnd, ex.cc, ex.e_dstE);
    end
  endtask

  task automatic test_stack;
    issue(1, 1, 8, 0, 4'hF, 0, 64'h100, 64'h80);
    n_checks++;
    if ({ex.e_valE, ex.e_dstE} !== {64'hF8, 4'h4}) begin
      n_fail++;
      $display("FAIL call: got valE=%h dstE=%h want F8/4", ex.e_valE, ex.e_dstE);
    end
    issue(1, 1, 4'hB, 0, 4'h2, 0, 64'hF8, 0);
    n_checks++;
    if ({ex.e_valE, ex.e_dstE} !== {64'h100, 4'h4}) begin
      n_fail++;
      $display("FAIL popq: got valE=%h dstE=%h want 100/4", ex.e_valE, ex.e_dstE);
    end
    issue(1, 1, 5, 0, 4'h3, 0, 64'h20, 64'h8);
    n_checks++;
    if ({ex.e_valE, ex.e_dstE} !== {64'h28, 4'hF}) begin
      n_fail++;
      $display("FAIL mrmovq: got valE=%h dstE=%h want 28/F", ex.e_valE, ex.e_dstE);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 6, 3, 4'h9, 64'h5A, 64'h5A, 0);
      n_checks++;
      if ({ex.e_icode, ex.e_valE, ex.e_dstE, ex.cc} !== {4'h5, 64'h28, 4'hF, 3'b010}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got icode=%h valE=%h dstE=%h cc=%b want 5/28/F/010",
                 i, ex.e_icode, ex.e_valE, ex.e_dstE, ex.cc);
      end
    end
    issue(1, 1, 6, 3, 4'h9, 64'h5A, 64'h5A, 0);
    n_checks++;
    if ({ex.e_valE, ex.e_dstE, ex.cc} !== {64'h0, 4'h9, 3'b100}) begin
      n_fail++;
      $display("FAIL stall_resume: got valE=%h dstE=%h cc=%b want 0/9/100", ex.e_valE, ex.e_dstE, ex.cc);
    end
  endtask

  task automatic test_error_halt;
    issue(1, 1, 6, 7, 4'h2, 64'h11, 64'h3, 0);
    n_checks++;
    if ({ex.e_error, ex.e_halted, ex.e_valE, ex.e_dstE, ex.e_Cnd, ex.cc, ex.e_icode} !==
        {1'b1, 1'b1, 64'h0, 4'hF, 1'b0, 3'b100, 4'h6}) begin
      n_fail++;
      $display("FAIL opq_bad_ifun: got err=%b halt=%b valE=%h dstE=%h Cnd=%b cc=%b icode=%h want 1/1/0/F/0/100/6",
               ex.e_error, ex.e_halted, ex.e_valE, ex.e_dstE, ex.e_Cnd, ex.cc, ex.e_icode);
    end
    issue(1, 1, 6, 0, 4'h1, 64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    n_checks++;
    if ({ex.e_valA, ex.e_valE, ex.cc, ex.e_halted} !== {64'h11, 64'h0, 3'b100, 1'b1}) begin
      n_fail++;
      $display("FAIL frozen: got valA=%h valE=%h cc=%b halt=%b want 11/0/100/1",
               ex.e_valA, ex.e_valE, ex.cc, ex.e_halted);
    end
    issue(0, 0, 6, 0, 4'h1, 0, 0, 0);
    n_checks++;
    if ({ex.e_error, ex.e_halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_clears: got err=%b halt=%b want 0/0", ex.e_error, ex.e_halted);
    end
    issue(1, 1, 0, 0, 4'hF, 0, 0, 0);
    n_checks++;
    if ({ex.e_halted, ex.e_error, ex.e_icode} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL halt: got halt=%b err=%b icode=%h want 1/0/0", ex.e_halted, ex.e_error, ex.e_icode);
    end
  endtask

  function automatic bit [63:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 64'h8000_0000_0000_0000;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'($urandom_range(0, 16));
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random;
    bit [3:0] ic, fn;
    bit       r, e;
    bit [141:0] got, want;
    issue(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r  = !((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0);
      e  = $urandom_range(0, 5) != 0;
      ic = ($urandom_range(0, 25) == 0) ? 4'($urandom) : 4'($urandom_range(1, 11));
      case (ic)
        4'd6:       fn = 4'($urandom_range(0, 3));
        4'd2, 4'd7: fn = 4'($urandom_range(0, 6));
        default:    fn = 4'd0;
      endcase
      if ($urandom_range(0, 30) == 0) fn = 4'($urandom);
      issue(r, e, ic, fn, 4'($urandom), pick_val(), pick_val(), pick_val());
      got  = {ex.e_icode, ex.e_valE, ex.e_valA, ex.e_Cnd, ex.e_dstE, ex.cc, ex.e_error, ex.e_halted};
      want = {m_icode, m_valE, m_valA, m_cnd, m_dstE, m_zf, m_sf, m_of, m_err, m_halt};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random[%0d] ic=%h fn=%h: got %h want %h", i, ic, fn, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_cond();
    test_stack();
    test_stall();
    test_error_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
